// File: rtl/pipe_sched_if.sv
// Pipeline-to-scheduler bundle: ID/EX hazard inputs and pipeline control outputs.
interface pipe_sched_if;
    logic [31:0] id_ins;
    logic [4:0]  ex_rd;
    logic        ex_load;
    logic        ex_br_taken;
    logic        mdu_req;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic [1:0]  pc_sel;
    logic        mdu_busy;
    logic [15:0] stall_cnt;

    // Pipeline side drives the hazard inputs and consumes the controls.
    modport master (
        output id_ins, ex_rd, ex_load, ex_br_taken, mdu_req,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, pc_sel, mdu_busy, stall_cnt
    );

    // Scheduler side.
    modport slave (
        input  id_ins, ex_rd, ex_load, ex_br_taken, mdu_req,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, pc_sel, mdu_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_sched.sv
// Pipeline hazard scheduler: branch flush, load-use stall, multi-cycle MDU hold, jump redirect.
module pipe_sched #(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_sched_if.slave bus
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned STALL_W = 16;

    localparam logic [CNT_W-1:0]   MDU_LOAD  = CNT_W'(MDU_LAT - 2);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_JMP = 2'd1;
    localparam logic [1:0] PC_BR  = 2'd2;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MDU_WAIT  = 2'd1,
        MDU_ISSUE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STALL_W-1:0] stall_q;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic       load_use;
    logic       jump;
    logic       unused_bits;

    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic [1:0] pc_sel;
    logic       mdu_busy;

    assign opcode      = bus.id_ins[31:26];
    assign rs          = bus.id_ins[25:21];
    assign rt          = bus.id_ins[20:16];
    assign unused_bits = ^bus.id_ins[15:0];

    // Which source fields the ID instruction actually reads.
    always_comb begin
        rs_used = 1'b0;
        rt_used = 1'b0;
        case (opcode)
            6'b000000, 6'b101011, 6'b000100, 6'b000101: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            6'b001000, 6'b100011: rs_used = 1'b1;
            default: ;
        endcase
    end

    assign load_use = bus.ex_load && (bus.ex_rd != 5'd0) &&
                      ((rs_used && (bus.ex_rd == rs)) || (rt_used && (bus.ex_rd == rt)));
    assign jump     = (opcode == 6'b000010) || (opcode == 6'b000011);

    // State and MDU counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; MDU_WAIT leaves once the counter reaches zero after its decrement.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (!bus.ex_br_taken && !load_use && bus.mdu_req) begin
                    state_d = MDU_WAIT;
                    cnt_d   = MDU_LOAD;
                end
            end
            MDU_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if (cnt_q <= CNT_ONE) begin
                    state_d = MDU_ISSUE;
                end
            end
            MDU_ISSUE: state_d = RUN;
            default:   state_d = RUN;
        endcase
    end

    // Pipeline controls; held at the RUN defaults while reset is asserted.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pc_sel       = PC_SEQ;
        mdu_busy     = 1'b0;
        if (rst_n) begin
            case (state_q)
                RUN: begin
                    if (bus.ex_br_taken) begin
                        pc_sel       = PC_BR;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (bus.mdu_req) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                        mdu_busy     = 1'b1;
                    end else if (jump) begin
                        pc_sel       = PC_JMP;
                        if_id_flush  = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                    mdu_busy     = 1'b1;
                end
                MDU_ISSUE: mdu_busy = 1'b1;
                default: ;
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!pc_en && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.pc_sel       = pc_sel;
    assign bus.mdu_busy     = mdu_busy;
    assign bus.stall_cnt    = stall_q;

endmodule
